// File: rtl/demux_1_8_wr_if.sv
// Bundles the write side, the eight bank outputs and the reader handshake of demux_1_8_wr.
interface demux_1_8_wr_if #(
  parameter int unsigned dw = 128
);
  logic [dw*9-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            clear;
  logic [dw*9-1:0] bank_data_0;
  logic [dw*9-1:0] bank_data_1;
  logic [dw*9-1:0] bank_data_2;
  logic [dw*9-1:0] bank_data_3;
  logic [dw*9-1:0] bank_data_4;
  logic [dw*9-1:0] bank_data_5;
  logic [dw*9-1:0] bank_data_6;
  logic [dw*9-1:0] bank_data_7;
  logic [7:0]      bank_vld;
  logic [2:0]      rd_sel;
  logic            rd_valid;
  logic            rd_ack;
  logic [3:0]      count;
  logic            full;
  logic            empty;

  modport master (
    output in_data, in_valid, clear, rd_ack,
    input  in_ready, bank_data_0, bank_data_1, bank_data_2, bank_data_3,
           bank_data_4, bank_data_5, bank_data_6, bank_data_7,
           bank_vld, rd_sel, rd_valid, count, full, empty
  );

  modport slave (
    input  in_data, in_valid, clear, rd_ack,
    output in_ready, bank_data_0, bank_data_1, bank_data_2, bank_data_3,
           bank_data_4, bank_data_5, bank_data_6, bank_data_7,
           bank_vld, rd_sel, rd_valid, count, full, empty
  );
endinterface

// File: rtl/demux_1_8_wr.sv
// Eight-bank circular write demux: windows land in bank[wr_ptr], the reader drains
// them in order through rd_sel / rd_ack; bank contents feed a downstream 8:1 mux.
module demux_1_8_wr #(
  parameter int unsigned dw = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_1_8_wr_if.slave  bus
);
  localparam int unsigned W = dw * 9;

  logic [W-1:0] bank [8];
  logic [7:0]   vld;
  logic [2:0]   wr_ptr;
  logic [2:0]   rd_ptr;
  logic [3:0]   cnt;
  logic         in_ready;
  logic         rd_valid;
  logic         wr_en;
  logic         rd_en;

  assign in_ready = (cnt != 4'd8);
  assign rd_valid = vld[rd_ptr];
  assign wr_en    = bus.in_valid & in_ready & ~bus.clear;
  assign rd_en    = bus.rd_ack & rd_valid & ~bus.clear;

  // wr_ptr == rd_ptr with both enables only when empty (rd_en low) or full (wr_en low),
  // so the clear-bit and set-bit updates below never target the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) bank[i] <= '0;
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.clear) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (rd_en) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 3'd1;
      end
      if (wr_en) begin
        bank[wr_ptr] <= bus.in_data;
        vld[wr_ptr]  <= 1'b1;
        wr_ptr       <= wr_ptr + 3'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_sel      = rd_ptr;
  assign bus.bank_vld    = vld;
  assign bus.count       = cnt;
  assign bus.full        = (cnt == 4'd8);
  assign bus.empty       = (cnt == 4'd0);
  assign bus.bank_data_0 = bank[0];
  assign bus.bank_data_1 = bank[1];
  assign bus.bank_data_2 = bank[2];
  assign bus.bank_data_3 = bank[3];
  assign bus.bank_data_4 = bank[4];
  assign bus.bank_data_5 = bank[5];
  assign bus.bank_data_6 = bank[6];
  assign bus.bank_data_7 = bank[7];
endmodule

// File: tb/tb_demux_1_8_wr.sv
// Randomized and directed checking of demux_1_8_wr against a queue-based occupancy model.
module tb_demux_1_8_wr;
  localparam int unsigned DW = 8;
  localparam int unsigned W  = DW * 9;

  logic clk;
  logic rst_n;

  demux_1_8_wr_if #(.dw(DW)) bus ();
  demux_1_8_wr #(.dw(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned chk_cnt;
  int unsigned pass_cnt;

  // Reference model: unread windows in arrival order plus bank image and pointer positions.
  logic [W-1:0] q[$];
  logic [W-1:0] mbank [8];
  int unsigned  wp;
  int unsigned  rp;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] bank_out(input int unsigned k);
    case (k)
      0: return bus.bank_data_0;
      1: return bus.bank_data_1;
      2: return bus.bank_data_2;
      3: return bus.bank_data_3;
      4: return bus.bank_data_4;
      5: return bus.bank_data_5;
      6: return bus.bank_data_6;
      default: return bus.bank_data_7;
    endcase
  endfunction

  function automatic logic [W-1:0] pat(input int unsigned n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(n * 17 + i * 3 + 1);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    wp = 0;
    rp = 0;
    for (int i = 0; i < 8; i++) mbank[i] = '0;
  endtask

  task automatic check_all();
    logic [7:0] ev;
    ev = '0;
    for (int i = 0; i < q.size(); i++) ev[(rp + i) % 8] = 1'b1;
    check("count",    W'(bus.count),    W'(q.size()));
    check("bank_vld", W'(bus.bank_vld), W'(ev));
    check("rd_sel",   W'(bus.rd_sel),   W'(rp));
    check("rd_valid", W'(bus.rd_valid), W'(q.size() > 0));
    check("in_ready", W'(bus.in_ready), W'(q.size() < 8));
    check("full",     W'(bus.full),     W'(q.size() == 8));
    check("empty",    W'(bus.empty),    W'(q.size() == 0));
    for (int k = 0; k < 8; k++) check($sformatf("bank_data_%0d", k), bank_out(k), mbank[k]);
  endtask

  // Drive one cycle at posedge+1, predict acceptance from pre-edge occupancy, check at next posedge+1.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ack, input logic clr);
    bit do_wr, do_rd;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.rd_ack   = ack;
    bus.clear    = clr;
    do_wr = iv && (q.size() < 8) && !clr;
    do_rd = ack && (q.size() > 0) && !clr;
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      wp = 0;
      rp = 0;
    end else begin
      if (do_rd) begin
        void'(q.pop_front());
        rp = (rp + 1) % 8;
      end
      if (do_wr) begin
        mbank[wp] = d;
        q.push_back(d);
        wp = (wp + 1) % 8;
      end
    end
    check_all();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count",    W'(bus.count),    W'(0));
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_empty",    W'(bus.empty),    W'(1));
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int unsigned n;

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    n        = 0;
    rst_n    = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_ack   = 1'b0;
    bus.clear    = 1'b0;
    #2;
    pulse_reset();
    @(posedge clk);
    #1;

    // Fill 8 plus a refused 9th write.
    for (int i = 0; i < 9; i++) cycle(1'b1, pat(n++), 1'b0, 1'b0);
    check("fill_vld",  W'(bus.bank_vld), W'(8'hFF));
    check("fill_full", W'(bus.full),     W'(1));
    check("fill_b7",   bus.bank_data_7,  pat(7));

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      check("drain_sel", W'(bus.rd_sel), W'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", W'(bus.empty), W'(1));

    // Ack on empty with a write in the same cycle.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, pat(100), 1'b1, 1'b0);
    check("empty_wr_ack", W'(bus.count), W'(1));

    // Wrap: write 8, read 6, write 6 (14 writes, 6 reads total).
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, pat(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 8; i < 14; i++) cycle(1'b1, pat(200 + i), 1'b0, 1'b0);
    check("wrap_sel",   W'(bus.rd_sel),  W'(6));
    check("wrap_count", W'(bus.count),   W'(8));
    check("wrap_b0",    bus.bank_data_0, pat(208));
    check("wrap_b5",    bus.bank_data_5, pat(213));

    // Simultaneous read/write at count 3, then full with ack.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, pat(n++), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, pat(n++), 1'b1, 1'b0);
    check("simul_count", W'(bus.count),  W'(3));
    check("simul_sel",   W'(bus.rd_sel), W'(5));
    for (int i = 0; i < 5; i++) cycle(1'b1, pat(n++), 1'b0, 1'b0);
    cycle(1'b1, pat(n++), 1'b1, 1'b0);
    check("full_ack_count", W'(bus.count), W'(7));

    // Clear with a concurrent write at count 5.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, pat(n++), 1'b0, 1'b0);
    cycle(1'b1, pat(n++), 1'b1, 1'b1);
    check("clear_vld", W'(bus.bank_vld), W'(0));

    // Reset mid-write, then first write goes to bank 0.
    for (int i = 0; i < 5; i++) cycle(1'b1, pat(n++), 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    pulse_reset();
    cycle(1'b1, pat(300), 1'b0, 1'b0);
    check("post_rst_b0", bus.bank_data_0, pat(300));

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
